// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the WB and ML result producers.
// Each requester has a one-entry slot; pending values are visible to decode.
module regfile_write_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ml_valid,
    output logic        ml_ready,
    input  logic [4:0]  ml_addr,
    input  logic [31:0] ml_data,
    output logic        rf_write_enable,
    output logic [4:0]  rf_addr_write,
    output logic [31:0] rf_in,
    input  logic [4:0]  query_addr,
    output logic        query_hit,
    output logic [31:0] query_data
);
    localparam logic [3:0] CntMax = 4'(MAX_WAIT);

    logic        wb_v_q, wb_v_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        ml_v_q, ml_v_d;
    logic [4:0]  ml_addr_q, ml_addr_d;
    logic [31:0] ml_data_q, ml_data_d;
    logic [3:0]  cnt_q, cnt_d;

    logic same_addr;
    logic gnt_wb;
    logic gnt_ml;
    logic ml_lose;
    logic wb_xfer;
    logic ml_xfer;
    logic wb_hit;
    logic ml_hit;

    // A same-register collision means the ML value is dead: WB is younger.
    assign same_addr = wb_v_q && ml_v_q && (wb_addr_q == ml_addr_q);
    assign gnt_ml    = ml_v_q && !same_addr && (!wb_v_q || cnt_q == CntMax);
    assign gnt_wb    = wb_v_q && !gnt_ml;
    assign ml_lose   = ml_v_q && !gnt_ml && !same_addr;

    assign wb_ready = !wb_v_q || gnt_wb;
    assign ml_ready = !ml_v_q || gnt_ml || same_addr;
    assign wb_xfer  = wb_valid && wb_ready;
    assign ml_xfer  = ml_valid && ml_ready;

    always_comb begin
        rf_write_enable = 1'b0;
        rf_addr_write   = '0;
        rf_in           = '0;
        unique case (1'b1)
            gnt_wb: begin
                rf_write_enable = 1'b1;
                rf_addr_write   = wb_addr_q;
                rf_in           = wb_data_q;
            end
            gnt_ml: begin
                rf_write_enable = 1'b1;
                rf_addr_write   = ml_addr_q;
                rf_in           = ml_data_q;
            end
            default: ;
        endcase
    end

    assign wb_hit = wb_v_q && (wb_addr_q == query_addr) && (query_addr != '0);
    assign ml_hit = ml_v_q && (ml_addr_q == query_addr) && (query_addr != '0);

    always_comb begin
        query_hit  = wb_hit || ml_hit;
        query_data = '0;
        if (wb_hit) begin
            query_data = wb_data_q;
        end else if (ml_hit) begin
            query_data = ml_data_q;
        end
    end

    always_comb begin
        wb_v_d    = wb_v_q && !gnt_wb;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        ml_v_d    = ml_v_q && !gnt_ml && !same_addr;
        ml_addr_d = ml_addr_q;
        ml_data_d = ml_data_q;
        // Writes to x0 are accepted but never occupy a slot.
        if (wb_xfer) begin
            wb_v_d    = (wb_addr != '0);
            wb_addr_d = wb_addr;
            wb_data_d = wb_data;
        end
        if (ml_xfer) begin
            ml_v_d    = (ml_addr != '0);
            ml_addr_d = ml_addr;
            ml_data_d = ml_data;
        end
        cnt_d = '0;
        if (ml_lose) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_v_q    <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            ml_v_q    <= 1'b0;
            ml_addr_q <= '0;
            ml_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            wb_v_q    <= wb_v_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            ml_v_q    <= ml_v_d;
            ml_addr_q <= ml_addr_d;
            ml_data_q <= ml_data_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus a randomized
// run checked against a slot-level reference model.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ml_valid;
    logic [4:0]  ml_addr;
    logic [31:0] ml_data;
    logic [4:0]  query_addr;

    logic        wb_ready, ml_ready, rf_write_enable, query_hit;
    logic [4:0]  rf_addr_write;
    logic [31:0] rf_in, query_data;

    logic        wb_ready4, ml_ready4, rf_write_enable4, query_hit4;
    logic [4:0]  rf_addr_write4;
    logic [31:0] rf_in4, query_data4;

    int n_checks = 0;
    int n_pass = 0;

    logic [31:0] rf_mem [32];

    regfile_write_arbiter #(.MAX_WAIT(2)) u_dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .ml_valid(ml_valid), .ml_ready(ml_ready),
        .ml_addr(ml_addr), .ml_data(ml_data),
        .rf_write_enable(rf_write_enable),
        .rf_addr_write(rf_addr_write), .rf_in(rf_in),
        .query_addr(query_addr), .query_hit(query_hit),
        .query_data(query_data)
    );

    regfile_write_arbiter #(.MAX_WAIT(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready4),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .ml_valid(ml_valid), .ml_ready(ml_ready4),
        .ml_addr(ml_addr), .ml_data(ml_data),
        .rf_write_enable(rf_write_enable4),
        .rf_addr_write(rf_addr_write4), .rf_in(rf_in4),
        .query_addr(query_addr), .query_hit(query_hit4),
        .query_data(query_data4)
    );

    always @(posedge clk) begin
        if (rf_write_enable) rf_mem[rf_addr_write] <= rf_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0;
        ml_valid = 1'b0;
        wb_addr = '0;
        ml_addr = '0;
        wb_data = '0;
        ml_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        query_addr = 5'd5;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (rf_write_enable !== 1'b0)
            $display("FAIL reset_we: got %b want 0", rf_write_enable);
        else n_pass++;
        n_checks++;
        if ({wb_ready, ml_ready} !== 2'b11)
            $display("FAIL reset_ready: got %b want 11", {wb_ready, ml_ready});
        else n_pass++;
        n_checks++;
        if (query_hit !== 1'b0)
            $display("FAIL reset_query: got %b want 0", query_hit);
        else n_pass++;
    endtask

    task automatic test_wb_basic();
        wb_valid = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'd42;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if ({rf_write_enable, rf_addr_write, rf_in} !== {1'b1, 5'd5, 32'd42})
            $display("FAIL wb_write: got %b/%0d/%0d want 1/5/42",
                     rf_write_enable, rf_addr_write, rf_in);
        else n_pass++;
        tick();
        n_checks++;
        if (rf_mem[5] !== 32'd42)
            $display("FAIL wb_rf_x5: got %0d want 42", rf_mem[5]);
        else n_pass++;
        n_checks++;
        if ({rf_write_enable, rf_addr_write, rf_in} !== 38'd0)
            $display("FAIL wb_idle_zero: got %b/%0d/%0d want 0/0/0",
                     rf_write_enable, rf_addr_write, rf_in);
        else n_pass++;
    endtask

    task automatic test_starvation();
        logic [4:0] exp_a [7] = '{5'd1, 5'd2, 5'd7, 5'd3, 5'd4, 5'd5, 5'd6};
        logic exp_r [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] exp_d;
        int nxt;
        wb_valid = 1'b1;
        wb_addr = 5'd1;
        wb_data = 32'd10;
        ml_valid = 1'b1;
        ml_addr = 5'd7;
        ml_data = 32'd99;
        tick();
        ml_valid = 1'b0;
        nxt = 2;
        for (int i = 0; i < 7; i++) begin
            wb_valid = (nxt <= 6);
            wb_addr = 5'(nxt);
            wb_data = 32'(nxt * 10);
            #1;
            exp_d = (exp_a[i] == 5'd7) ? 32'd99 : 32'(exp_a[i]) * 32'd10;
            n_checks++;
            if ({rf_write_enable, rf_addr_write, rf_in} !== {1'b1, exp_a[i], exp_d})
                $display("FAIL starve_write[%0d]: got %b/%0d/%0d want 1/%0d/%0d",
                         i, rf_write_enable, rf_addr_write, rf_in, exp_a[i], exp_d);
            else n_pass++;
            n_checks++;
            if (wb_ready !== exp_r[i])
                $display("FAIL starve_wb_ready[%0d]: got %b want %b",
                         i, wb_ready, exp_r[i]);
            else n_pass++;
            if (exp_r[i] && wb_valid) nxt++;
            tick();
        end
        idle_inputs();
        #1;
        n_checks++;
        if (rf_write_enable !== 1'b0 || u_dut.cnt_q !== 4'd0)
            $display("FAIL starve_drain: got we=%b cnt=%0d want 0/0",
                     rf_write_enable, u_dut.cnt_q);
        else n_pass++;
        n_checks++;
        if (rf_mem[7] !== 32'd99)
            $display("FAIL starve_rf_x7: got %0d want 99", rf_mem[7]);
        else n_pass++;
    endtask

    task automatic test_same_addr();
        wb_valid = 1'b1;
        wb_addr = 5'd9;
        wb_data = 32'd22;
        ml_valid = 1'b1;
        ml_addr = 5'd9;
        ml_data = 32'd11;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if ({rf_write_enable, rf_addr_write, rf_in} !== {1'b1, 5'd9, 32'd22})
            $display("FAIL same_write: got %b/%0d/%0d want 1/9/22",
                     rf_write_enable, rf_addr_write, rf_in);
        else n_pass++;
        n_checks++;
        if (ml_ready !== 1'b1)
            $display("FAIL same_ml_ready: got %b want 1", ml_ready);
        else n_pass++;
        tick();
        query_addr = 5'd9;
        #1;
        n_checks++;
        if ({rf_write_enable, query_hit} !== 2'b00)
            $display("FAIL same_discard: got we=%b hit=%b want 0/0",
                     rf_write_enable, query_hit);
        else n_pass++;
        n_checks++;
        if (rf_mem[9] !== 32'd22)
            $display("FAIL same_rf_x9: got %0d want 22", rf_mem[9]);
        else n_pass++;
    endtask

    task automatic test_query();
        wb_valid = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'd5;
        ml_valid = 1'b1;
        ml_addr = 5'd4;
        ml_data = 32'd6;
        tick();
        idle_inputs();
        query_addr = 5'd4;
        #1;
        n_checks++;
        if ({query_hit, query_data} !== {1'b1, 32'd6})
            $display("FAIL query_x4: got %b/%0d want 1/6", query_hit, query_data);
        else n_pass++;
        query_addr = 5'd3;
        #1;
        n_checks++;
        if ({query_hit, query_data} !== {1'b1, 32'd5})
            $display("FAIL query_x3: got %b/%0d want 1/5", query_hit, query_data);
        else n_pass++;
        query_addr = 5'd0;
        #1;
        n_checks++;
        if ({query_hit, query_data} !== 33'd0)
            $display("FAIL query_x0: got %b/%0d want 0/0", query_hit, query_data);
        else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_zero_addr();
        wb_valid = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'd77;
        tick();
        idle_inputs();
        query_addr = 5'd0;
        #1;
        n_checks++;
        if ({rf_write_enable, wb_ready, query_hit} !== 3'b010)
            $display("FAIL zero_addr: got we=%b rdy=%b hit=%b want 0/1/0",
                     rf_write_enable, wb_ready, query_hit);
        else n_pass++;
    endtask

    task automatic test_reset_midstall();
        int bad;
        wb_valid = 1'b1;
        wb_addr = 5'd1;
        wb_data = 32'd1;
        ml_valid = 1'b1;
        ml_addr = 5'd7;
        ml_data = 32'h777;
        tick();
        ml_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            wb_addr = 5'(k);
            wb_data = 32'(k);
            tick();
        end
        n_checks++;
        if (u_dut4.cnt_q !== 4'd3 || ml_ready4 !== 1'b0)
            $display("FAIL midstall_setup: got cnt=%0d ml_rdy=%b want 3/0",
                     u_dut4.cnt_q, ml_ready4);
        else n_pass++;
        reset = 1'b1;
        wb_addr = 5'd5;
        ml_valid = 1'b1;
        ml_addr = 5'd8;
        tick();
        reset = 1'b0;
        idle_inputs();
        query_addr = 5'd7;
        #1;
        n_checks++;
        if ({rf_write_enable4, query_hit4, wb_ready4, ml_ready4} !== 4'b0011)
            $display("FAIL midstall_after_reset: got we=%b hit=%b rdy=%b%b want 0/0/11",
                     rf_write_enable4, query_hit4, wb_ready4, ml_ready4);
        else n_pass++;
        n_checks++;
        if (u_dut4.cnt_q !== 4'd0 || rf_write_enable !== 1'b0)
            $display("FAIL midstall_cnt: got cnt=%0d we2=%b want 0/0",
                     u_dut4.cnt_q, rf_write_enable);
        else n_pass++;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            query_addr = 5'(k + 4);
            #1;
            if (rf_write_enable4 || query_hit4) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0)
            $display("FAIL midstall_no_write: got %0d busy cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_random();
        localparam int M = 2;
        localparam int N = 400;
        logic        mw_v, mm_v;
        logic [4:0]  mw_a, mm_a;
        logic [31:0] mw_d, mm_d;
        int          lost, win;
        logic        same, er_wb, er_ml, e_we, e_hit;
        logic [4:0]  e_a;
        logic [31:0] e_d, e_qd;
        logic [72:0] exp_v, got_v;
        int          errs;
        mw_v = 0; mm_v = 0; mw_a = 0; mm_a = 0; mw_d = 0; mm_d = 0;
        lost = 0;
        errs = 0;
        for (int i = 0; i < N + 6; i++) begin
            wb_valid = (i < N) && ($urandom_range(0, 2) != 0);
            ml_valid = (i < N) && ($urandom_range(0, 2) == 0);
            wb_addr = 5'($urandom_range(0, 3));
            ml_addr = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            ml_data = $urandom;
            query_addr = 5'($urandom_range(0, 3));
            #1;
            same = mw_v && mm_v && (mw_a == mm_a);
            if (mm_v && !same && (!mw_v || lost >= M)) win = 2;
            else if (mw_v) win = 1;
            else win = 0;
            er_wb = !mw_v || win == 1;
            er_ml = !mm_v || win == 2 || same;
            e_we = (win != 0);
            e_a = (win == 1) ? mw_a : (win == 2) ? mm_a : 5'd0;
            e_d = (win == 1) ? mw_d : (win == 2) ? mm_d : 32'd0;
            e_hit = 1'b0;
            e_qd = 32'd0;
            if (query_addr != 0 && mw_v && mw_a == query_addr) begin
                e_hit = 1'b1;
                e_qd = mw_d;
            end else if (query_addr != 0 && mm_v && mm_a == query_addr) begin
                e_hit = 1'b1;
                e_qd = mm_d;
            end
            exp_v = {er_wb, er_ml, e_we, e_a, e_d, e_hit, e_qd};
            got_v = {wb_ready, ml_ready, rf_write_enable, rf_addr_write,
                     rf_in, query_hit, query_data};
            n_checks++;
            if (got_v !== exp_v) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got %h want %h", i, got_v, exp_v);
            end else n_pass++;
            if (mm_v && win != 2 && !same) lost = (lost < M) ? lost + 1 : M;
            else lost = 0;
            if (win == 1) mw_v = 0;
            if (win == 2 || same) mm_v = 0;
            if (wb_valid && er_wb) begin
                mw_v = (wb_addr != 0);
                mw_a = wb_addr;
                mw_d = wb_data;
            end
            if (ml_valid && er_ml) begin
                mm_v = (ml_addr != 0);
                mm_a = ml_addr;
                mm_d = ml_data;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        query_addr = '0;
        idle_inputs();
        #1;
        test_reset();
        test_wb_basic();
        test_starvation();
        test_same_addr();
        test_query();
        test_zero_addr();
        test_reset_midstall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
